// File: rtl/updi_link_pkg.sv
// updi_pkg: shared types and constants for the UPDI link-layer controller.
//   UPDI_SYNCH         - synchronisation character sent before every instruction
//   updi_link_state_t  - link controller state encoding
//   updi_link_err_t    - error flag bundle {frame, timeout, echo}
package updi_pkg;

  localparam logic [7:0] UPDI_SYNCH = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNCH_TX,
    ST_ECHO,
    ST_BYTE_TX,
    ST_RESP,
    ST_BREAK,
    ST_DONE
  } updi_link_state_t;

  typedef struct packed {
    logic frame;
    logic timeout;
    logic echo;
  } updi_link_err_t;

endpackage

// File: rtl/updi_link_if.sv
// updi_link_if: command-sequencer side of the UPDI link controller.
//   cmd_data/cmd_valid/cmd_last/cmd_resp_len/cmd_ready - instruction byte stream
//   resp_data/resp_valid                              - received response bytes
//   done + echo_err/timeout_err/frame_err             - end-of-transaction status
//   break_req                                         - standalone BREAK request
// modport master: command sequencer; modport slave: updi_link.
interface updi_link_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_last;
  logic [3:0] cmd_resp_len;
  logic       cmd_ready;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       done;
  logic       echo_err;
  logic       timeout_err;
  logic       frame_err;
  logic       break_req;

  modport master (
    output cmd_data, cmd_valid, cmd_last, cmd_resp_len, break_req,
    input  cmd_ready, resp_data, resp_valid, done, echo_err, timeout_err, frame_err
  );

  modport slave (
    input  cmd_data, cmd_valid, cmd_last, cmd_resp_len, break_req,
    output cmd_ready, resp_data, resp_valid, done, echo_err, timeout_err, frame_err
  );
endinterface

// File: rtl/updi_link_timeout.sv
// updi_timeout: loadable saturating up-counter.
//   clk, rst (async, active-low)
//   clr      - synchronous clear to zero (highest priority)
//   load     - load load_val
//   en       - count up by one; holds at LIMIT, never wraps
//   expired  - counter equals LIMIT
module updi_timeout #(
  parameter int LIMIT = 65535,
  parameter int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != LIMIT_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT_V);

endmodule

// File: rtl/updi_link.sv
// updi_link: UPDI link-layer controller above the uart byte engine.
// Prefixes each instruction with SYNCH, consumes and checks the echo of every
// transmitted byte, collects response bytes and drives BREAK on faults.
// Ports:
//   clk, rst (async, active-low)
//   cmd            - updi_link_if.slave (sequencer side, response and status)
//   tx_data, transmit_start / transmit_ready - uart transmit side
//   rx_data, rx_data_valid, rx_error          - uart receive side
//   line_break     - forces the tx line low while high
// Build option: UPDI_LINK_ECHO_CHECK_EN enables comparing each echo against
// the transmitted byte; without it echo_err stays 0.
module updi_link
  import updi_pkg::*;
#(
  parameter int RESP_TIMEOUT = 65535,
  parameter int BREAK_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst,
  updi_link_if.slave cmd,
  output logic [7:0] tx_data,
  output logic       transmit_start,
  input  logic       transmit_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       rx_error,
  output logic       line_break
);

  updi_link_state_t state, state_nxt;
  updi_link_err_t   err_q, err_set;

  logic [7:0] tx_data_q, resp_data_q;
  logic [3:0] resp_len_q, remain_q;
  logic       start_q, synch_q, last_q;
  logic       resp_valid_q, done_q, line_break_q;
  logic       cmd_ready_c, cmd_hs, synch_start, resp_fire;
  logic       waiting, tmo_expired, brk_expired, echo_bad;

`ifdef UPDI_LINK_ECHO_CHECK_EN
  assign echo_bad = (rx_data != tx_data_q);
`else
  assign echo_bad = 1'b0;
`endif

  assign waiting = (state == ST_ECHO) || (state == ST_RESP);

  // Inter-byte watchdog: restarts on every received byte.
  updi_timeout #(.LIMIT(RESP_TIMEOUT)) u_resp_tmo (
    .clk(clk), .rst(rst), .clr(rx_data_valid || !waiting), .load(1'b0),
    .load_val('0), .en(waiting), .expired(tmo_expired)
  );

  // BREAK duration: expired on the last of BREAK_CYCLES cycles in BREAK.
  updi_timeout #(.LIMIT(BREAK_CYCLES - 1)) u_brk_tmo (
    .clk(clk), .rst(rst), .clr(state != ST_BREAK), .load(1'b0),
    .load_val('0), .en(state == ST_BREAK), .expired(brk_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    err_set     = '0;
    cmd_ready_c = 1'b0;
    cmd_hs      = 1'b0;
    synch_start = 1'b0;
    resp_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd.cmd_valid)      state_nxt = ST_SYNCH_TX;
        else if (cmd.break_req) state_nxt = ST_BREAK;
      end
      ST_SYNCH_TX: begin
        if (transmit_ready) begin
          synch_start = 1'b1;
          state_nxt   = ST_ECHO;
        end
      end
      ST_BYTE_TX: begin
        cmd_ready_c = transmit_ready && !start_q;
        cmd_hs      = cmd_ready_c && cmd.cmd_valid;
        if (cmd_hs) state_nxt = ST_ECHO;
      end
      ST_ECHO: begin
        if (rx_data_valid) begin
          // A framing error outranks a data mismatch on the same byte.
          if (rx_error) begin
            err_set.frame = 1'b1;
            state_nxt     = ST_BREAK;
          end else if (echo_bad) begin
            err_set.echo = 1'b1;
            state_nxt    = ST_BREAK;
          end else if (synch_q || !last_q) begin
            state_nxt = ST_BYTE_TX;
          end else if (resp_len_q != 4'd0) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_DONE;
          end
        end else if (tmo_expired) begin
          err_set.timeout = 1'b1;
          state_nxt       = ST_BREAK;
        end
      end
      ST_RESP: begin
        if (rx_data_valid) begin
          if (rx_error) begin
            err_set.frame = 1'b1;
            state_nxt     = ST_BREAK;
          end else begin
            resp_fire = 1'b1;
            if (remain_q == 4'd1) state_nxt = ST_DONE;
          end
        end else if (tmo_expired) begin
          err_set.timeout = 1'b1;
          state_nxt       = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (brk_expired) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_q    <= '0;
      resp_data_q  <= '0;
      resp_len_q   <= '0;
      remain_q     <= '0;
      start_q      <= 1'b0;
      synch_q      <= 1'b0;
      last_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      done_q       <= 1'b0;
      line_break_q <= 1'b0;
      err_q        <= '0;
    end else begin
      start_q      <= cmd_hs;
      resp_valid_q <= resp_fire;
      done_q       <= (state == ST_DONE);
      line_break_q <= (state_nxt == ST_BREAK);
      // Flags accumulate through BREAK and clear right after the done strobe.
      err_q        <= done_q ? '0 : (err_q | err_set);
      if ((state == ST_IDLE) && cmd.cmd_valid) begin
        resp_len_q <= cmd.cmd_resp_len;
        tx_data_q  <= UPDI_SYNCH;
        synch_q    <= 1'b1;
      end
      if (cmd_hs) begin
        tx_data_q <= cmd.cmd_data;
        last_q    <= cmd.cmd_last;
        synch_q   <= 1'b0;
      end
      if ((state == ST_ECHO) && (state_nxt == ST_RESP)) remain_q <= resp_len_q;
      if (resp_fire) begin
        resp_data_q <= rx_data;
        remain_q    <= remain_q - 4'd1;
      end
    end
  end

  // SYNCH launches combinationally so it leaves one cycle after cmd_valid.
  assign transmit_start  = synch_start || start_q;
  assign tx_data         = tx_data_q;
  assign line_break      = line_break_q;
  assign cmd.cmd_ready   = cmd_ready_c;
  assign cmd.resp_data   = resp_data_q;
  assign cmd.resp_valid  = resp_valid_q;
  assign cmd.done        = done_q;
  assign cmd.frame_err   = err_q.frame;
  assign cmd.timeout_err = err_q.timeout;
  assign cmd.echo_err    = err_q.echo;

endmodule

// File: tb/tb_updi_link.sv
// tb_updi_link: self-checking bench for updi_link.
// A behavioural uart/target model echoes every transmitted byte and replies
// with response bytes; a reference model predicts, per transaction, the byte
// sequence on the wire, the response stream, the error flags and BREAK length.
// Honours UPDI_LINK_ECHO_CHECK_EN for the expected echo_err behaviour.
module tb_updi_link;
  localparam int RT = 40;
  localparam int BC = 12;
`ifdef UPDI_LINK_ECHO_CHECK_EN
  localparam bit ECHO_CHK = 1'b1;
`else
  localparam bit ECHO_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       transmit_start;
  logic       transmit_ready;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_error;
  logic       line_break;

  updi_link_if cif();

  updi_link #(.RESP_TIMEOUT(RT), .BREAK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst_n), .cmd(cif),
    .tx_data(tx_data), .transmit_start(transmit_start), .transmit_ready(transmit_ready),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_error(rx_error),
    .line_break(line_break)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [7:0] tx_log[$];
  logic [7:0] resp_log[$];
  logic [7:0] reply_q[$];
  int         fire_cyc[$];
  int         hs_cyc[$];
  int         done_cnt, brk_cnt, brk_first, done_cyc, last_rx_cyc;
  logic [2:0] got_flags;
  int         rx_evt, echo_done, reply_after, corrupt_at, rxerr_at, busy, gap;
  bit         launch;
  logic [7:0] cur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: monitor DUT outputs at the falling edge, then advance the uart model.
  task automatic step();
    logic fire;
    @(negedge clk);
    cyc++;
    fire = transmit_start && transmit_ready;
    if (cif.resp_valid) resp_log.push_back(cif.resp_data);
    if (cif.done) begin
      done_cnt++;
      done_cyc  = cyc;
      got_flags = {cif.frame_err, cif.timeout_err, cif.echo_err};
    end
    if (line_break) begin
      brk_cnt++;
      if (brk_first < 0) brk_first = cyc;
      reply_q.delete();
    end
    rx_data_valid = 1'b0;
    rx_error      = 1'b0;
    if (launch) begin
      launch         = 1'b0;
      transmit_ready = 1'b0;
      busy           = $urandom_range(1, 5);
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        rx_data_valid  = 1'b1;
        rx_data        = (rx_evt == corrupt_at) ? (cur ^ 8'h01) : cur;
        rx_error       = (rx_evt == rxerr_at);
        rx_evt++;
        echo_done++;
        last_rx_cyc    = cyc;
        transmit_ready = 1'b1;
      end
    end else if ((echo_done >= reply_after) && (reply_q.size() > 0)) begin
      if (gap > 0) gap--;
      else begin
        rx_data_valid = 1'b1;
        rx_data       = reply_q.pop_front();
        rx_error      = (rx_evt == rxerr_at);
        rx_evt++;
        last_rx_cyc   = cyc;
        gap           = $urandom_range(0, 4);
      end
    end
    if (fire) begin
      tx_log.push_back(tx_data);
      fire_cyc.push_back(cyc);
      cur    = tx_data;
      launch = 1'b1;
    end
  endtask

  task automatic run_txn(input logic [7:0] bytes[$], input int rlen, input logic [7:0] replies[$],
                         input int corrupt_i, input int rxerr_i, input bit with_brk);
    logic [7:0] sent[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_resp[$];
    bit ef, et, ee, stop;
    int idx, c0, budget;
    bit hs_pend;
    // Reference: walk the wire events in order, stopping at the first fault.
    sent = {8'h55, bytes};
    ef = 0; et = 0; ee = 0; stop = 0;
    for (int i = 0; i < sent.size() && !stop; i++) begin
      exp_tx.push_back(sent[i]);
      if (rxerr_i == i) begin ef = 1; stop = 1; end
      else if (ECHO_CHK && corrupt_i == i) begin ee = 1; stop = 1; end
    end
    for (int j = 0; j < rlen && !stop; j++) begin
      if (j >= replies.size()) begin et = 1; stop = 1; end
      else if (rxerr_i == sent.size() + j) begin ef = 1; stop = 1; end
      else exp_resp.push_back(replies[j]);
    end

    tx_log.delete(); resp_log.delete(); fire_cyc.delete(); hs_cyc.delete();
    done_cnt = 0; brk_cnt = 0; brk_first = -1; got_flags = '0;
    rx_evt = 0; echo_done = 0; reply_after = sent.size(); reply_q = replies;
    corrupt_at = corrupt_i; rxerr_at = rxerr_i; gap = $urandom_range(0, 3);

    idx = 0; hs_pend = 0; c0 = cyc; budget = 0;
    cif.cmd_valid    = 1'b1;
    cif.cmd_data     = bytes[0];
    cif.cmd_last     = (bytes.size() == 1);
    cif.cmd_resp_len = 4'(rlen);
    cif.break_req    = with_brk;
    while (done_cnt == 0 && budget < 3000) begin
      step();
      budget++;
      cif.break_req = 1'b0;
      if (hs_pend) begin
        hs_pend = 0;
        idx++;
        cif.cmd_resp_len = 4'($urandom);
        if (idx < bytes.size()) begin
          cif.cmd_data = bytes[idx];
          cif.cmd_last = (idx == bytes.size() - 1);
        end else begin
          cif.cmd_valid = 1'b0;
        end
      end
      if (line_break) cif.cmd_valid = 1'b0;
      if (cif.cmd_valid && cif.cmd_ready) begin
        hs_pend = 1;
        hs_cyc.push_back(cyc);
      end
    end
    cif.cmd_valid = 1'b0;
    repeat (3) step();

    chk("done_count", done_cnt, 1);
    chk("flags", got_flags, {ef, et, ee});
    chk("flags_cleared", {cif.frame_err, cif.timeout_err, cif.echo_err}, 0);
    chk("tx_count", tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) chk("tx_byte", tx_log[i], exp_tx[i]);
    chk("resp_count", resp_log.size(), exp_resp.size());
    for (int i = 0; i < exp_resp.size() && i < resp_log.size(); i++) chk("resp_byte", resp_log[i], exp_resp[i]);
    chk("break_cycles", brk_cnt, (ef || et || ee) ? BC : 0);
    if (fire_cyc.size() > 0) chk("synch_latency", fire_cyc[0] - c0, 1);
    for (int i = 0; i < hs_cyc.size() && i + 1 < fire_cyc.size(); i++)
      chk("byte_start_latency", fire_cyc[i + 1] - hs_cyc[i], 1);
    if (!(ef || et || ee)) chk("done_latency", done_cyc - last_rx_cyc, 2);
    if (et) chk("timeout_to_break", brk_first - last_rx_cyc, RT + 2);
  endtask

  task automatic run_break(input bit do_reset);
    int b;
    done_cnt = 0; brk_cnt = 0; got_flags = '1; reply_q.delete();
    cif.break_req = 1'b1;
    step();
    cif.break_req = 1'b0;
    if (do_reset) begin
      repeat (4) step();
      chk("break_active", line_break, 1);
      rst_n = 1'b0;
      #1;
      chk("reset_line_break", line_break, 0);
      chk("reset_outputs", {tx_data, transmit_start, cif.done, cif.resp_valid, cif.cmd_ready,
                            cif.frame_err, cif.timeout_err, cif.echo_err}, 0);
      launch = 1'b0; busy = 0; transmit_ready = 1'b1;
      step(); step();
      rst_n = 1'b1;
      step();
    end else begin
      b = 0;
      while (done_cnt == 0 && b < 500) begin step(); b++; end
      chk("break_done", done_cnt, 1);
      chk("break_len", brk_cnt, BC);
      chk("break_flags", got_flags, 0);
    end
  endtask

  initial begin
    logic [7:0] q_a[$], q_b[$], none[$];
    int n, rlen, nrep, cor, rxe;
    rst_n = 1'b0;
    transmit_ready = 1'b1; rx_data = '0; rx_data_valid = 1'b0; rx_error = 1'b0;
    cif.cmd_data = '0; cif.cmd_valid = 1'b0; cif.cmd_last = 1'b0;
    cif.cmd_resp_len = '0; cif.break_req = 1'b0;
    launch = 0; busy = 0; gap = 0; corrupt_at = -1; rxerr_at = -1;
    rx_evt = 0; echo_done = 0; reply_after = 1; brk_first = -1;
    repeat (3) step();
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_outs", {transmit_start, line_break, cif.done, cif.resp_valid, cif.cmd_ready,
                       cif.frame_err, cif.timeout_err, cif.echo_err}, 0);
    rst_n = 1'b1;
    repeat (2) step();

    q_a = {8'h80};
    run_txn(q_a, 0, none, -1, -1, 0);          // clean single byte
    run_txn(q_a, 1, none, -1, -1, 0);          // missing response -> timeout
    q_a = {8'h24}; q_b = {8'h1E, 8'h94};
    run_txn(q_a, 2, q_b, -1, -1, 0);           // two response bytes
    q_a = {8'h80};
    run_txn(q_a, 0, none, 1, -1, 0);           // echo of 0x80 returns as 0x81
    q_a = {8'h24}; q_b = {8'h11, 8'h22, 8'h33};
    run_txn(q_a, 3, q_b, -1, 3, 0);            // rx_error on second response byte
    q_a = {8'h44, 8'h12, 8'h34}; q_b = {8'hA5, 8'h5A};
    run_txn(q_a, 2, q_b, -1, -1, 1);           // cmd_valid wins over break_req
    run_break(0);
    run_break(1);
    q_a = {8'h80};
    run_txn(q_a, 0, none, -1, -1, 0);          // recovers after reset

    for (int t = 0; t < 30; t++) begin
      q_a.delete(); q_b.delete();
      n = $urandom_range(1, 4);
      rlen = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) q_a.push_back(8'($urandom));
      nrep = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rlen) : rlen;
      for (int i = 0; i < nrep; i++) q_b.push_back(8'($urandom));
      cor = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
      rxe = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n + rlen) : -1;
      run_txn(q_a, rlen, q_b, cor, rxe, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
